// File: rtl/game_screen_controller.sv
// Game screen controller: frame tick generation, IDLE/PLAYING/HIT/GAME_OVER
// sequencing with lives and score, and a registered output pixel mux.
module game_screen_controller #(
  parameter int SCREEN_WIDTH     = 1280,
  parameter int SCREEN_HEIGHT    = 720,
  parameter int MAX_LIVES        = 3,
  parameter int HIT_FRAMES       = 60,
  parameter int BLINK_FRAMES     = 15,
  parameter int GAME_OVER_FRAMES = 180
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_in,
  input  logic        wall_hit_in,
  input  logic        wall_pass_in,
  input  logic [23:0] playfield_pixel_in,
  input  logic [23:0] game_over_pixel_in,
  output logic [1:0]  state_out,
  output logic [1:0]  lives_out,
  output logic [7:0]  score_out,
  output logic        frame_tick_out,
  output logic [23:0] pixel_out
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_HIT       = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam logic [10:0] WIDTH_C  = 11'(SCREEN_WIDTH);
  localparam logic [9:0]  HEIGHT_C = 10'(SCREEN_HEIGHT);
  localparam logic [1:0]  LIVES_C  = 2'(MAX_LIVES);
  localparam logic [7:0]  HIT_C    = 8'(HIT_FRAMES);
  localparam logic [7:0]  BLINK_C  = 8'(BLINK_FRAMES);
  localparam logic [7:0]  GO_C     = 8'(GAME_OVER_FRAMES);

  state_t      state_r, state_s;
  logic [1:0]  lives_r, lives_s;
  logic [7:0]  score_r, score_s;
  logic [7:0]  frame_cnt_r, frame_cnt_s;
  logic        tick_cond_s, tick_cond_d_r, tick_armed_r, frame_tick_r;
  logic        active_s, blink_s;
  logic [23:0] pixel_r, pixel_s;

  assign tick_cond_s = (hcount_in == 11'd0) && (vcount_in == HEIGHT_C);
  assign active_s    = (hcount_in < WIDTH_C) && (vcount_in < HEIGHT_C);
  assign blink_s     = ((frame_cnt_r / BLINK_C) % 8'd2) == 8'd1;

  // Frame tick edge detector; armed only once the condition has been seen low,
  // so a condition already held at reset release cannot produce a tick.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tick_cond_d_r <= 1'b0;
      tick_armed_r  <= 1'b0;
      frame_tick_r  <= 1'b0;
    end else begin
      tick_cond_d_r <= tick_cond_s;
      tick_armed_r  <= tick_armed_r | ~tick_cond_s;
      frame_tick_r  <= tick_cond_s & ~tick_cond_d_r & tick_armed_r;
    end
  end

  // State, lives, score and frame counter registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r     <= ST_IDLE;
      lives_r     <= 2'd0;
      score_r     <= 8'd0;
      frame_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      lives_r     <= lives_s;
      score_r     <= score_s;
      frame_cnt_r <= frame_cnt_s;
    end
  end

  // Next-state logic; a hit outranks a simultaneous pass.
  always_comb begin
    state_s     = state_r;
    lives_s     = lives_r;
    score_s     = score_r;
    frame_cnt_s = frame_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start_in) begin
          state_s     = ST_PLAYING;
          lives_s     = LIVES_C;
          score_s     = 8'd0;
          frame_cnt_s = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PLAYING: begin
        if (wall_hit_in) begin
          lives_s     = lives_r - 2'd1;
          frame_cnt_s = 8'd0;
          state_s     = (lives_r == 2'd1) ? ST_GAME_OVER : ST_HIT;
        end else if (wall_pass_in) begin
          score_s = (score_r == 8'hFF) ? 8'hFF : score_r + 8'd1;
        end else begin
          state_s = ST_PLAYING;
        end
      end
      ST_HIT: begin
        if (frame_cnt_r == HIT_C) begin
          state_s     = ST_PLAYING;
          frame_cnt_s = 8'd0;
        end else if (frame_tick_r) begin
          frame_cnt_s = frame_cnt_r + 8'd1;
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
      end
      ST_GAME_OVER: begin
        if (start_in || (frame_cnt_r == GO_C)) begin
          state_s     = ST_IDLE;
          frame_cnt_s = 8'd0;
        end else if (frame_tick_r) begin
          frame_cnt_s = frame_cnt_r + 8'd1;
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Pixel source selection; blanking outside the active area.
  always_comb begin
    pixel_s = 24'h000000;
    if (!active_s) begin
      pixel_s = 24'h000000;
    end else begin
      case (state_r)
        ST_IDLE:      pixel_s = 24'h000000;
        ST_PLAYING:   pixel_s = playfield_pixel_in;
        ST_HIT:       pixel_s = blink_s ? 24'hFFFFFF : playfield_pixel_in;
        ST_GAME_OVER: pixel_s = game_over_pixel_in;
        default:      pixel_s = 24'h000000;
      endcase
    end
  end

  // Output pixel register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pixel_r <= 24'h000000;
    end else begin
      pixel_r <= pixel_s;
    end
  end

  assign state_out      = state_r;
  assign lives_out      = lives_r;
  assign score_out      = score_r;
  assign frame_tick_out = frame_tick_r;
  assign pixel_out      = pixel_r;

endmodule
